// File: rtl/pbkdf2_multiblock.sv
// pbkdf2_multiblock: PBKDF2 iteration controller in front of an external HMAC PRF core.
// For each block i = 1..N it issues U_1 = PRF(S||INT(i)), then U_j = PRF(U_{j-1}) up to
// c requests, XOR-accumulates the results into T_i and emits T_i on the block port.
// Ports:
//   clk_i, rst_ni                        clock, async active-low reset
//   start_i, iters_i, num_blocks_i,      job start and parameters (sampled in IDLE)
//   salt_i
//   busy_o                               job in progress
//   prf_v_o/prf_r_i, prf_first_o,        PRF request channel (message MSB-aligned,
//   prf_msg_o, prf_len_o                 length in bytes)
//   prf_v_i/prf_r_o, prf_data_i          PRF result channel
//   blk_v_o/blk_r_i, blk_data_o,         derived block channel
//   blk_idx_o, blk_last_o
//   abort_i                              only when PBKDF2_ABORT_EN is defined
// Optional feature macro: PBKDF2_ABORT_EN (adds abort_i).
module pbkdf2_multiblock #(
  parameter int unsigned HASH_W = 256,
  parameter int unsigned SALT_W = 256,
  parameter int unsigned ITER_W = 32,
  parameter int unsigned BLK_W  = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
`ifdef PBKDF2_ABORT_EN
  input  logic                abort_i,
`endif
  input  logic                start_i,
  input  logic [ITER_W-1:0]   iters_i,
  input  logic [BLK_W-1:0]    num_blocks_i,
  input  logic [SALT_W-1:0]   salt_i,
  output logic                busy_o,
  output logic                prf_v_o,
  input  logic                prf_r_i,
  output logic                prf_first_o,
  output logic [SALT_W+31:0]  prf_msg_o,
  output logic [15:0]         prf_len_o,
  input  logic                prf_v_i,
  output logic                prf_r_o,
  input  logic [HASH_W-1:0]   prf_data_i,
  output logic                blk_v_o,
  input  logic                blk_r_i,
  output logic [HASH_W-1:0]   blk_data_o,
  output logic [BLK_W-1:0]    blk_idx_o,
  output logic                blk_last_o
);

  localparam int unsigned MSG_W = SALT_W + 32;
  localparam int unsigned PAD_W = MSG_W - HASH_W;
  localparam logic [15:0] LEN_FIRST = 16'(SALT_W / 8 + 4);
  localparam logic [15:0] LEN_NEXT  = 16'(HASH_W / 8);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_OUT} state_e;

  state_e              state;
  logic [ITER_W-1:0]   c_q;
  logic [BLK_W-1:0]    n_q;
  logic [SALT_W-1:0]   salt_q;
  logic [HASH_W-1:0]   acc;
  logic [ITER_W-1:0]   iter_cnt;
  logic [BLK_W-1:0]    blk_cnt;

  logic [ITER_W-1:0]   iter_inc_c;
  logic [BLK_W-1:0]    blk_inc_c;
  logic [HASH_W-1:0]   acc_nx_c;
  logic                abort_c;

  // iter_cnt never exceeds c-1 before the increment, so this cannot wrap
  assign iter_inc_c = iter_cnt + ITER_W'(1);
  assign blk_inc_c  = blk_cnt + BLK_W'(1);
  assign acc_nx_c   = acc ^ prf_data_i;

`ifdef PBKDF2_ABORT_EN
  assign abort_c = abort_i;
`else
  assign abort_c = 1'b0;
`endif

  // Controller: state, counters and all outputs registered in one process
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= S_IDLE;
      c_q         <= '0;
      n_q         <= '0;
      salt_q      <= '0;
      acc         <= '0;
      iter_cnt    <= '0;
      blk_cnt     <= '0;
      busy_o      <= 1'b0;
      prf_v_o     <= 1'b0;
      prf_first_o <= 1'b0;
      prf_msg_o   <= '0;
      prf_len_o   <= '0;
      prf_r_o     <= 1'b0;
      blk_v_o     <= 1'b0;
      blk_data_o  <= '0;
      blk_idx_o   <= '0;
      blk_last_o  <= 1'b0;
    end else if (abort_c && (state != S_IDLE)) begin
      // Abort discards any handshake completing this cycle
      state       <= S_IDLE;
      acc         <= '0;
      iter_cnt    <= '0;
      blk_cnt     <= '0;
      busy_o      <= 1'b0;
      prf_v_o     <= 1'b0;
      prf_first_o <= 1'b0;
      prf_r_o     <= 1'b0;
      blk_v_o     <= 1'b0;
      blk_last_o  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start_i) begin
            c_q         <= (iters_i == '0) ? ITER_W'(1) : iters_i;
            n_q         <= (num_blocks_i == '0) ? BLK_W'(1) : num_blocks_i;
            salt_q      <= salt_i;
            blk_cnt     <= BLK_W'(1);
            iter_cnt    <= '0;
            acc         <= '0;
            busy_o      <= 1'b1;
            prf_v_o     <= 1'b1;
            prf_first_o <= 1'b1;
            prf_msg_o   <= {salt_i, 32'd1};
            prf_len_o   <= LEN_FIRST;
            state       <= S_REQ;
          end
        end
        S_REQ: begin
          if (prf_r_i) begin
            prf_v_o     <= 1'b0;
            prf_first_o <= 1'b0;
            prf_r_o     <= 1'b1;
            state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (prf_v_i) begin
            prf_r_o  <= 1'b0;
            acc      <= acc_nx_c;
            iter_cnt <= iter_inc_c;
            if (iter_inc_c == c_q) begin
              blk_v_o    <= 1'b1;
              blk_data_o <= acc_nx_c;
              blk_idx_o  <= blk_cnt;
              blk_last_o <= (blk_cnt == n_q);
              state      <= S_OUT;
            end else begin
              // Next message is U_prev MSB-aligned; the output register doubles as U_prev
              prf_v_o     <= 1'b1;
              prf_first_o <= 1'b0;
              prf_msg_o   <= MSG_W'(prf_data_i) << PAD_W;
              prf_len_o   <= LEN_NEXT;
              state       <= S_REQ;
            end
          end
        end
        S_OUT: begin
          if (blk_r_i) begin
            blk_v_o <= 1'b0;
            if (blk_last_o) begin
              blk_last_o <= 1'b0;
              busy_o     <= 1'b0;
              state      <= S_IDLE;
            end else begin
              blk_cnt     <= blk_inc_c;
              iter_cnt    <= '0;
              acc         <= '0;
              prf_v_o     <= 1'b1;
              prf_first_o <= 1'b1;
              prf_msg_o   <= {salt_q, 32'(blk_inc_c)};
              prf_len_o   <= LEN_FIRST;
              state       <= S_REQ;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
